univ_shift_reg_burst: RTL



---
 rtl/univ_shift_reg_burst.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg_burst.sv
// Universal WIDTH-bit shift register with hold/shift/load/rotate/arith/clear modes and a counted burst engine.
// Optional macro SHREG_PARITY_EN adds a registered A_parity output tracking ^A_par.
module univ_shift_reg_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] A_par,
  output logic             SO_lsb,
  output logic             SO_msb,
  output logic             busy,
`ifdef SHREG_PARITY_EN
  output logic             A_parity,
`endif
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next register value for a given mode; serial fill bits are always taken live.
  function automatic logic [WIDTH-1:0] mode_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] ipar,
    input logic             msb_fill,
    input logic             lsb_fill
  );
    logic [WIDTH-1:0] r;
    r = a;
    case (m)
      M_HOLD: r = a;
      M_SHR:  r = {msb_fill, a[WIDTH-1:1]};
      M_SHL:  r = {a[WIDTH-2:0], lsb_fill};
      M_LOAD: r = ipar;
      M_ROR:  r = {a[0], a[WIDTH-1:1]};
      M_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
      M_ASR:  r = {a[WIDTH-1], a[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic is_shift_class(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) || (m == M_ROL) || (m == M_ASR);
  endfunction

  // Next-state, datapath and decoded status
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_shift_class(s)) begin
          if (count != '0) begin
            mode_d  = s;
            cnt_d   = count;
            state_d = ST_BURST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          a_d = mode_op(s, a_q, I_par, MSB_in, LSB_in);
        end
      end
      ST_BURST: begin
        a_d   = mode_op(mode_q, a_q, I_par, MSB_in, LSB_in);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_BURST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SHREG_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = ^a_d;
  end

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign A_parity = parity_q;
`endif

  assign A_par  = a_q;
  assign SO_lsb = a_q[0];
  assign SO_msb = a_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
